mem_access_unit: RTL and testbench

//  Requester side of the data-memory interface. Takes load/store requests from the
//  CPU execute stage over a valid/ready handshake and drives registered op/address/

---
 rtl/mem_access_unit_pkg.sv | 28 ++
 rtl/mem_access_unit_if.sv | 36 +++
 rtl/mem_access_unit_sat_counter.sv | 26 ++
 rtl/mem_access_unit.sv | 124 ++++++++++++
 tb/tb_mem_access_unit.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory requester: widths, opcodes, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mem_defs;

  localparam int OP_W   = 4;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int REG_W  = 10;
  localparam int TAG_W  = 3;
  localparam int CNT_W  = 16;

  localparam logic [OP_W-1:0] OP_LOAD  = 4'b1101;
  localparam logic [OP_W-1:0] OP_STORE = 4'b1110;
  localparam logic [OP_W-1:0] OP_NOP   = 4'b0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Only loads and stores are ever forwarded to the memory.
  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request, memory and response bundle between execute, the unit, memory and writeback.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready on the request side, resp_valid/resp_ready on the result side.
interface mem_access_unit_if;
  import mem_defs::*;

  logic              req_valid;
  logic              req_ready;
  logic [OP_W-1:0]   req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [REG_W-1:0]  req_ra;
  logic [TAG_W-1:0]  req_tag;

  logic [OP_W-1:0]   mem_op;
  logic [ADDR_W-1:0] mem_addr;
  logic [REG_W-1:0]  mem_ra;
  logic [DATA_W-1:0] mem_rdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [TAG_W-1:0]  resp_tag;

  // The access unit side.
  modport slave (
    input  req_valid, req_op, req_addr, req_ra, req_tag, mem_rdata, resp_ready,
    output req_ready, mem_op, mem_addr, mem_ra, resp_valid, resp_data, resp_tag
  );

  // The environment side: execute stage, data memory and writeback together.
  modport master (
    output req_valid, req_op, req_addr, req_ra, req_tag, mem_rdata, resp_ready,
    input  req_ready, mem_op, mem_addr, mem_ra, resp_valid, resp_data, resp_tag
  );

endinterface

// File: rtl/mem_access_unit_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
// Latency: count updates on the rising edge after inc.
// Backpressure: none; inc at saturation is silently dropped.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;

  // Count up on inc unless already at the maximum value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/mem_access_unit.sv
// Requester side of the data memory: issues loads/stores, returns load bytes with a tag.
// Latency: accept edge plus one ISSUE cycle; load result valid on the edge after accept.
// Backpressure: req_ready only in IDLE; a result is held in RESP until resp_ready.
module mem_access_unit
  import mem_defs::*;
(
  input  logic             clk,
  input  logic             rst_n,
  mem_access_unit_if.slave bus,
  output logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] store_cnt
);

  state_t            state_q, state_d;
  logic [OP_W-1:0]   mem_op_q, mem_op_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [REG_W-1:0]  mem_ra_q, mem_ra_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic [TAG_W-1:0]  resp_tag_q, resp_tag_d;
  logic              load_inc;
  logic              store_inc;

  // Next-state and next-register values; every target defaults to hold.
  always_comb begin
    state_d      = state_q;
    mem_op_d     = mem_op_q;
    mem_addr_d   = mem_addr_q;
    mem_ra_d     = mem_ra_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_tag_d   = resp_tag_q;
    load_inc     = 1'b0;
    store_inc    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          // Unknown opcodes never reach the memory; mem_op stays NOP so
          // nothing is written, and ISSUE treats them as pass-through.
          mem_op_d   = is_mem_op(bus.req_op) ? bus.req_op : OP_NOP;
          mem_addr_d = bus.req_addr;
          mem_ra_d   = bus.req_ra;
          resp_tag_d = bus.req_tag;
          state_d    = ISSUE;
        end
      end

      ISSUE: begin
        // mem_* were stable all cycle, so the memory's falling-edge write has landed.
        mem_op_d = OP_NOP;
        if (mem_op_q == OP_STORE) begin
          store_inc = 1'b1;
          state_d   = IDLE;
        end else if (mem_op_q == OP_LOAD) begin
          resp_data_d  = bus.mem_rdata;
          resp_valid_d = 1'b1;
          load_inc     = 1'b1;
          state_d      = RESP;
        end else begin
          // Pass-through of the captured address for non-memory opcodes.
          resp_data_d  = DATA_W'(mem_addr_q);
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end

      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_op_q     <= OP_NOP;
      mem_addr_q   <= '0;
      mem_ra_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
    end else begin
      state_q      <= state_d;
      mem_op_q     <= mem_op_d;
      mem_addr_q   <= mem_addr_d;
      mem_ra_q     <= mem_ra_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_tag_q   <= resp_tag_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_load_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (load_inc),
    .count (load_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_store_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (store_inc),
    .count (store_cnt)
  );

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.mem_op     = mem_op_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_ra     = mem_ra_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_tag   = resp_tag_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a byte memory model and response scoreboard.
// Latency: n/a.
// Backpressure: resp_ready driven per scenario.
module tb_mem_access_unit;
  import mem_defs::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CNT_W-1:0] load_cnt;
  logic [CNT_W-1:0] store_cnt;

  mem_access_unit_if bus();

  mem_access_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .load_cnt  (load_cnt),
    .store_cnt (store_cnt)
  );

  always #5 clk = ~clk;

  // Data memory model: combinational read, falling-edge write of the low byte.
  bit [7:0] mem     [256];
  bit [7:0] exp_mem [256];
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(negedge clk) begin
    if (bus.mem_op == OP_STORE) mem[bus.mem_addr] <= bus.mem_ra[DATA_W-1:0];
  end

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } resp_t;

  resp_t sb[$];
  int    errors = 0;
  int    checks = 0;
  int    exp_load = 0;
  int    exp_store = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and wait (bounded) for the edge that accepts it; returns just after that edge.
  task automatic send(input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] addr,
                      input logic [REG_W-1:0] ra, input logic [TAG_W-1:0] tag);
    bit ok;
    bit rdy;
    ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_ra    = ra;
    bus.req_tag   = tag;
    for (int i = 0; i < 20 && !ok; i++) begin
      rdy = bus.req_ready;
      tick();
      if (rdy) ok = 1'b1;
    end
    bus.req_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: op=%b accepted=0 required=1", op);
    end
  endtask

  // Wait (bounded) for a response, compare it with the scoreboard head, then retire it.
  task automatic collect(input string name, output int lat);
    bit    got;
    resp_t e;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.resp_valid) got = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    checks++;
    if (!got || sb.size() == 0) begin
      errors++;
      $display("FAIL %s_resp_timeout: resp_valid=%b queued=%0d required valid with 1 queued", name, bus.resp_valid, sb.size());
    end else begin
      e = sb.pop_front();
      checks++;
      if (bus.resp_data !== e.data) begin
        errors++;
        $display("FAIL %s_data: got %h want %h", name, bus.resp_data, e.data);
      end
      checks++;
      if (bus.resp_tag !== e.tag) begin
        errors++;
        $display("FAIL %s_tag: got %0d want %0d", name, bus.resp_tag, e.tag);
      end
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
      checks++;
      if (bus.resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s_retire: resp_valid=%b want 0", name, bus.resp_valid);
      end
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (bus.mem_op !== OP_NOP || bus.mem_addr !== '0 || bus.mem_ra !== '0) begin
      errors++;
      $display("FAIL %s_mem: op=%b addr=%h ra=%h want 0000/00/000", name, bus.mem_op, bus.mem_addr, bus.mem_ra);
    end
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.resp_data !== '0 || bus.resp_tag !== '0) begin
      errors++;
      $display("FAIL %s_resp: valid=%b data=%h tag=%0d want 0/00/0", name, bus.resp_valid, bus.resp_data, bus.resp_tag);
    end
    checks++;
    if (load_cnt !== '0 || store_cnt !== '0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_cnt_ready: load=%0d store=%0d ready=%b want 0/0/1", name, load_cnt, store_cnt, bus.req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_values("reset");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_store_load();
    int lat;
    send(OP_STORE, 8'h10, 10'h3A5, 3'd0);
    exp_mem[8'h10] = 8'hA5;
    exp_store++;
    checks++;
    if (bus.mem_op !== OP_STORE || bus.mem_addr !== 8'h10 || bus.mem_ra !== 10'h3A5) begin
      errors++;
      $display("FAIL store_issue: op=%b addr=%h ra=%h want 1110/10/3a5", bus.mem_op, bus.mem_addr, bus.mem_ra);
    end
    tick();
    checks++;
    if (mem[8'h10] !== exp_mem[8'h10]) begin
      errors++;
      $display("FAIL store_write: got %h want %h", mem[8'h10], exp_mem[8'h10]);
    end
    checks++;
    if (bus.mem_op !== OP_NOP || bus.req_ready !== 1'b1 || store_cnt !== CNT_W'(exp_store)) begin
      errors++;
      $display("FAIL store_done: op=%b ready=%b store_cnt=%0d want 0000/1/%0d", bus.mem_op, bus.req_ready, store_cnt, exp_store);
    end
    send(OP_LOAD, 8'h10, 10'h000, 3'd5);
    sb.push_back('{data: exp_mem[8'h10], tag: 3'd5});
    exp_load++;
    collect("load1", lat);
    // lat counts edges after the accept edge: accept + 1 = 2 edges.
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL load1_latency: got %0d edges after accept want 1", lat);
    end
    checks++;
    if (load_cnt !== CNT_W'(exp_load)) begin
      errors++;
      $display("FAIL load1_cnt: got %0d want %0d", load_cnt, exp_load);
    end
  endtask

  task automatic test_resp_backpressure();
    int lat;
    send(OP_STORE, 8'h11, 10'h25C, 3'd0);
    exp_mem[8'h11] = 8'h5C;
    exp_store++;
    tick();
    send(OP_LOAD, 8'h10, 10'h000, 3'd2);
    sb.push_back('{data: exp_mem[8'h10], tag: 3'd2});
    exp_load++;
    tick();
    // A competing request is presented while the result is stalled.
    bus.req_valid = 1'b1;
    bus.req_op    = OP_LOAD;
    bus.req_addr  = 8'h11;
    bus.req_ra    = 10'h000;
    bus.req_tag   = 3'd3;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_data !== exp_mem[8'h10] || bus.resp_tag !== 3'd2 ||
          bus.req_ready !== 1'b0 || bus.mem_op !== OP_NOP) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%b data=%h tag=%0d ready=%b op=%b want 1/%h/2/0/0000",
                 c, bus.resp_valid, bus.resp_data, bus.resp_tag, bus.req_ready, bus.mem_op, exp_mem[8'h10]);
      end
      tick();
    end
    collect("held", lat);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.mem_op !== OP_NOP) begin
      errors++;
      $display("FAIL no_accept_on_retire: ready=%b op=%b want 1/0000", bus.req_ready, bus.mem_op);
    end
    tick();
    bus.req_valid = 1'b0;
    checks++;
    if (bus.mem_op !== OP_LOAD || bus.mem_addr !== 8'h11) begin
      errors++;
      $display("FAIL second_accept: op=%b addr=%h want 1101/11", bus.mem_op, bus.mem_addr);
    end
    sb.push_back('{data: exp_mem[8'h11], tag: 3'd3});
    exp_load++;
    collect("second", lat);
  endtask

  task automatic test_passthrough();
    int lat;
    bit same;
    send(4'b0011, 8'h7E, 10'h155, 3'd6);
    checks++;
    if (bus.mem_op !== OP_NOP) begin
      errors++;
      $display("FAIL pass_mem_op: got %b want 0000", bus.mem_op);
    end
    sb.push_back('{data: 8'h7E, tag: 3'd6});
    collect("pass", lat);
    checks++;
    if (load_cnt !== CNT_W'(exp_load) || store_cnt !== CNT_W'(exp_store)) begin
      errors++;
      $display("FAIL pass_counters: load=%0d store=%0d want %0d/%0d", load_cnt, store_cnt, exp_load, exp_store);
    end
    same = 1'b1;
    for (int a = 0; a < 256; a++) if (mem[a] !== exp_mem[a]) same = 1'b0;
    checks++;
    if (!same) begin
      errors++;
      $display("FAIL pass_no_write: memory differs from expected contents, mem[7e]=%h want %h", mem[8'h7E], exp_mem[8'h7E]);
    end
  endtask

  task automatic test_back_to_back();
    int idx;
    int last_acc;
    bit rdy;
    idx = 0;
    last_acc = -1;
    bus.req_valid = 1'b1;
    bus.req_op    = OP_STORE;
    bus.req_addr  = 8'h00;
    bus.req_ra    = 10'h240;
    bus.req_tag   = 3'd0;
    for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
      rdy = bus.req_ready;
      tick();
      if (rdy) begin
        checks++;
        if (bus.mem_op !== OP_STORE || bus.mem_addr !== ADDR_W'(idx)) begin
          errors++;
          $display("FAIL b2b_issue%0d: op=%b addr=%h want 1110/%h", idx, bus.mem_op, bus.mem_addr, idx);
        end
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != 2) begin
            errors++;
            $display("FAIL b2b_spacing%0d: got %0d cycles want 2", idx, cyc - last_acc);
          end
        end
        last_acc = cyc;
        exp_mem[idx] = 8'h40 + 8'(idx * 8'h11);
        exp_store++;
        idx++;
        if (idx < 4) begin
          bus.req_addr = ADDR_W'(idx);
          bus.req_ra   = 10'h240 + 10'(idx * 8'h11);
        end else begin
          bus.req_valid = 1'b0;
        end
      end else begin
        checks++;
        if (bus.mem_op !== OP_NOP) begin
          errors++;
          $display("FAIL b2b_idle_op: got %b want 0000", bus.mem_op);
        end
      end
    end
    bus.req_valid = 1'b0;
    checks++;
    if (idx != 4) begin
      errors++;
      $display("FAIL b2b_count: accepted %0d want 4", idx);
    end
    tick();
    for (int a = 0; a < 4; a++) begin
      checks++;
      if (mem[a] !== exp_mem[a]) begin
        errors++;
        $display("FAIL b2b_byte%0d: got %h want %h", a, mem[a], exp_mem[a]);
      end
    end
    checks++;
    if (store_cnt !== CNT_W'(exp_store)) begin
      errors++;
      $display("FAIL b2b_store_cnt: got %0d want %0d", store_cnt, exp_store);
    end
  endtask

  task automatic test_reset_mid_op();
    send(OP_LOAD, 8'h02, 10'h000, 3'd4);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_load = 0;
    exp_store = 0;
    check_reset_values("rst_load");
    tick();
    checks++;
    if (bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_load_dropped: resp_valid=%b want 0", bus.resp_valid);
    end
    send(OP_STORE, 8'h40, 10'h1C7, 3'd0);
    rst_n = 1'b0;
    exp_mem[8'h40] = 8'hC7;
    tick();
    rst_n = 1'b1;
    checks++;
    if (mem[8'h40] !== exp_mem[8'h40]) begin
      errors++;
      $display("FAIL rst_store_write: got %h want %h", mem[8'h40], exp_mem[8'h40]);
    end
    checks++;
    if (store_cnt !== '0 || bus.mem_op !== OP_NOP) begin
      errors++;
      $display("FAIL rst_store_state: store_cnt=%0d op=%b want 0/0000", store_cnt, bus.mem_op);
    end
    tick();
  endtask

  task automatic test_counter_saturation();
    force dut.u_store_cnt.cnt_q = 16'hFFFE;
    tick();
    release dut.u_store_cnt.cnt_q;
    tick();
    checks++;
    if (store_cnt !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_preload: got %h want fffe", store_cnt);
    end
    for (int s = 0; s < 3; s++) begin
      send(OP_STORE, 8'h80 + 8'(s), 10'h011 + 10'(s), 3'd0);
      exp_mem[8'h80 + s] = 8'h11 + 8'(s);
      tick();
      checks++;
      if (store_cnt !== 16'hFFFF) begin
        errors++;
        $display("FAIL sat_store%0d: got %h want ffff", s, store_cnt);
      end
    end
    checks++;
    if (mem[8'h82] !== exp_mem[8'h82]) begin
      errors++;
      $display("FAIL sat_last_write: got %h want %h", mem[8'h82], exp_mem[8'h82]);
    end
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_op     = OP_NOP;
    bus.req_addr   = '0;
    bus.req_ra     = '0;
    bus.req_tag    = '0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_store_load();
    test_resp_backpressure();
    test_passthrough();
    test_back_to_back();
    test_reset_mid_op();
    test_counter_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
